// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding and BCD constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGITS   = 4;
    localparam int unsigned BCD_MAX      = 9999;
    localparam logic [15:0] BCD_SAT      = 16'h9999;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking (digits 3..1 -> 4'hF) with BIN2BCD_BLANK_EN.
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic [15:0]      bcd,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [15:0] BCD_RST = {BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE, 4'h0};
`else
    localparam logic [15:0] BCD_RST = 16'h0000;
`endif

    state_t             state, state_n;
    logic [15:0]        acc;
    logic [15:0]        acc_adj;
    logic [BIN_W-1:0]   bin_sh;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic [15:0]        result;
    logic               unused_carry;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    // The bit shifted out above the MSD is dropped; saturation covers that range.
    assign unused_carry = acc_adj[15];

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [15:0] blank_leading(input logic [15:0] v);
        logic [15:0] r;
        logic        leading;
        r       = v;
        leading = 1'b1;
        for (int unsigned i = BCD_DIGITS - 1; i >= 1; i--) begin
            if (leading && v[4*i +: 4] == 4'd0) begin
                r[4*i +: 4] = BLANK_NIBBLE;
            end else begin
                leading = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        result = acc;
`ifdef BIN2BCD_BLANK_EN
        result = blank_leading(acc);
`endif
        if (ovf_pend) begin
            result = BCD_SAT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start) state_n = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            bin_sh   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd      <= BCD_RST;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        bin_sh   <= bin;
                        ovf_pend <= (32'(bin) > BCD_MAX);
                        cnt      <= '0;
                    end
                end
                ST_SHIFT: begin
                    acc    <= {acc_adj[14:0], bin_sh[BIN_W-1]};
                    bin_sh <= bin_sh << 1;
                    cnt    <= cnt + 1'b1;
                end
                ST_DONE: begin
                    bcd      <= result;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=14 and BIN_W=8).
module tb_bin_to_bcd_seq;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [15:0] E_RST  = 16'hFFF0;
    localparam logic [15:0] E_0    = 16'hFFF0;
    localparam logic [15:0] E_7    = 16'hFFF7;
    localparam logic [15:0] E_42   = 16'hFF42;
    localparam logic [15:0] E_255  = 16'hF255;
`else
    localparam logic [15:0] E_RST  = 16'h0000;
    localparam logic [15:0] E_0    = 16'h0000;
    localparam logic [15:0] E_7    = 16'h0007;
    localparam logic [15:0] E_42   = 16'h0042;
    localparam logic [15:0] E_255  = 16'h0255;
`endif

    logic        clk;
    logic        reset;
    logic [13:0] bin;
    logic        start;
    logic [15:0] bcd;
    logic        busy, done, overflow;

    logic [7:0]  bin8;
    logic        start8;
    logic [15:0] bcd8;
    logic        busy8, done8, overflow8;

    int checks = 0;
    int errors = 0;
    int lat, busy_cnt, pulses;

    bin_to_bcd_seq dut (
        .clk(clk), .reset(reset), .bin(bin), .start(start),
        .bcd(bcd), .busy(busy), .done(done), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_W(8)) dut8 (
        .clk(clk), .reset(reset), .bin(bin8), .start(start8),
        .bcd(bcd8), .busy(busy8), .done(done8), .overflow(overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a start at the current negedge and wait for done; lat counts edges after the start edge.
    task automatic convert(input logic [13:0] b, output int l, output int bc);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l  = 0;
        bc = 0;
        while (done !== 1'b1 && l < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin    = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'(E_RST));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert(14'd1234, lat, busy_cnt);
        chk("1234_lat", 32'(lat), 32'd15);
        chk("1234_busycnt", 32'(busy_cnt), 32'd15);
        chk("1234_bcd", 32'(bcd), 32'h1234);
        chk("1234_ovf", 32'(overflow), 32'd0);
        chk("1234_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("1234_done_width", 32'(done), 32'd0);
        chk("1234_bcd_held", 32'(bcd), 32'h1234);

        convert(14'd0, lat, busy_cnt);
        chk("0_lat", 32'(lat), 32'd15);
        chk("0_bcd", 32'(bcd), 32'(E_0));
        chk("0_ovf", 32'(overflow), 32'd0);
        convert(14'd9999, lat, busy_cnt);
        chk("9999_b2b_lat", 32'(lat), 32'd15);
        chk("9999_bcd", 32'(bcd), 32'h9999);
        chk("9999_ovf", 32'(overflow), 32'd0);

        convert(14'd10000, lat, busy_cnt);
        chk("10000_bcd", 32'(bcd), 32'h9999);
        chk("10000_ovf", 32'(overflow), 32'd1);
        convert(14'd16383, lat, busy_cnt);
        chk("16383_bcd", 32'(bcd), 32'h9999);
        chk("16383_ovf", 32'(overflow), 32'd1);
        convert(14'd7, lat, busy_cnt);
        chk("7_bcd", 32'(bcd), 32'(E_7));
        chk("7_ovf", 32'(overflow), 32'd0);
        @(negedge clk);

        // 42 conversion with stray starts during SHIFT (c=3) and DONE (c=14)
        bin   = 14'd42;
        start = 1'b1;
        @(negedge clk);
        pulses = 0;
        lat    = -1;
        for (int c = 0; c < 35; c++) begin
            if (done === 1'b1) begin
                pulses++;
                lat = c;
            end
            start = (c == 3 || c == 14);
            bin   = start ? 14'd5555 : 14'd42;
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_lat", 32'(lat), 32'd15);
        chk("ign_bcd", 32'(bcd), 32'(E_42));
        chk("ign_busy", 32'(busy), 32'd0);

        // Reset during iteration 7 of a 4321 conversion
        convert(14'd7, lat, busy_cnt);
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'(E_RST));
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 32'(pulses), 32'd0);
        convert(14'd4321, lat, busy_cnt);
        chk("4321_lat", 32'(lat), 32'd15);
        chk("4321_bcd", 32'(bcd), 32'h4321);
        @(negedge clk);

        // BIN_W = 8 instance
        bin8   = 8'd255;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat    = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_lat", 32'(lat), 32'd9);
        chk("w8_bcd", 32'(bcd8), 32'(E_255));
        chk("w8_ovf", 32'(overflow8), 32'd0);
        chk("w8_busy", 32'(busy8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
